// File: rtl/snake_tick_gen.sv
// Programmable tick generator: counts down an adjustable period and emits a
// one-cycle tick each time it wraps. Drives the en_pulse input of the snake counters.
module snake_tick_gen #(
  parameter int                 WIDTH          = 20,
  parameter logic [WIDTH-1:0]   DEFAULT_PERIOD = 20'd500000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] period,
  input  logic             load,
  input  logic             run,
  output logic             tick,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] period_reg;
  logic [WIDTH-1:0] p_last;
  logic [WIDTH-1:0] load_rem;

  // A programmed period of zero behaves as a period of one.
  assign p_last   = (period_reg == '0) ? '0 : period_reg - ONE;
  assign load_rem = (period == '0) ? '0 : period - ONE;

  assign state_dbg = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      period_reg <= DEFAULT_PERIOD;
      remaining  <= '0;
      tick       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state     <= RUN;
            busy      <= 1'b1;
            remaining <= p_last;
          end
        end
        RUN: begin
          if (!run) begin
            state <= HOLD;
            busy  <= 1'b0;
          end else if (remaining == '0) begin
            remaining <= p_last;
            tick      <= 1'b1;
          end else begin
            remaining <= remaining - ONE;
          end
        end
        HOLD: begin
          if (run) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      // Load overrides the countdown and any terminal-count tick, but lets
      // the run-driven state transition above proceed on the same edge.
      if (load) begin
        period_reg <= period;
        remaining  <= load_rem;
        tick       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snake_tick_gen.sv
// Bench for snake_tick_gen: directed scenarios followed by random traffic,
// compared each cycle against a modular-arithmetic reference model.
module tb_snake_tick_gen;

  localparam int W   = 20;
  localparam int DEF = 37;

  logic         clock;
  logic         reset_n;
  logic [W-1:0] period;
  logic         load;
  logic         run;
  logic         tick;
  logic [W-1:0] remaining;
  logic         busy;
  logic [1:0]   state_dbg;

  int n_vec = 0;
  int n_err = 0;

  logic [W+1:0] exp_q[$];

  snake_tick_gen #(
    .WIDTH          (W),
    .DEFAULT_PERIOD (W'(DEF))
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .period    (period),
    .load      (load),
    .run       (run),
    .tick      (tick),
    .remaining (remaining),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // reference model: mode 0 = stopped, 1 = counting, 2 = paused.
  // remaining is (start - counted_edges) mod P.
  int m_mode, m_per, m_r0, m_k;

  function automatic int eff(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic int modp(input int a, input int p);
    return ((a % p) + p) % p;
  endfunction

  function automatic int model_rem();
    return modp(m_r0 - m_k, eff(m_per));
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_per  = DEF;
    m_r0   = 0;
    m_k    = 0;
  endtask

  task automatic model_step(input logic ld, input int p, input logic r);
    int    nm;
    logic  t;
    t  = 1'b0;
    nm = m_mode;
    if (m_mode == 0 && r)  nm = 1;
    if (m_mode == 1 && !r) nm = 2;
    if (m_mode == 2 && r)  nm = 1;
    if (ld) begin
      m_per = p;
      m_r0  = (p == 0) ? 0 : p - 1;
      m_k   = 0;
    end else if (m_mode == 0 && r) begin
      m_r0 = eff(m_per) - 1;
      m_k  = 0;
    end else if (m_mode == 1 && r) begin
      if (model_rem() == 0) t = 1'b1;
      m_k++;
    end
    m_mode = nm;
    exp_q.push_back({t, (m_mode == 1), W'(model_rem())});
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic cycle(input logic ld, input int p, input logic r);
    logic [W+1:0] e;
    @(negedge clock);
    load   = ld;
    period = W'(p);
    run    = r;
    model_step(ld, p, r);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("tick",      W'(tick),  W'(e[W+1]));
    check("busy",      W'(busy),  W'(e[W]));
    check("remaining", remaining, e[W-1:0]);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b1);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic apply_reset();
    @(negedge clock);
    load = 1'b0;
    run  = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_tick",      W'(tick), '0);
    check("rst_busy",      W'(busy), '0);
    check("rst_remaining", remaining, '0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    load    = 1'b0;
    run     = 1'b0;
    period  = '0;
    model_reset();
    #3;
    check("por_tick",      W'(tick), '0);
    check("por_busy",      W'(busy), '0);
    check("por_remaining", remaining, '0);
    @(negedge clock);
    reset_n = 1'b1;

    // stays idle with run low
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0);

    // period 3
    cycle(1'b1, 3, 1'b0);
    run_cycles(8);

    // period 0 behaves as 1
    apply_reset();
    cycle(1'b1, 0, 1'b0);
    run_cycles(6);

    // pause at remaining 2 with period 5
    apply_reset();
    cycle(1'b1, 5, 1'b0);
    run_cycles(3);
    check("pause_rem", remaining, W'(2));
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b0);
    run_cycles(7);

    // load colliding with terminal count
    apply_reset();
    cycle(1'b1, 4, 1'b0);
    run_cycles(4);
    check("coll_rem0", remaining, W'(0));
    cycle(1'b1, 6, 1'b1);
    run_cycles(8);

    // load on the same edge as IDLE->RUN
    apply_reset();
    cycle(1'b1, 3, 1'b1);
    run_cycles(5);

    // reset mid-run, then default period
    apply_reset();
    cycle(1'b1, 10, 1'b0);
    run_cycles(6);
    check("mid_rem4", remaining, W'(4));
    apply_reset();
    run_cycles(2 * DEF + 3);

    // random traffic
    begin
      logic r;
      r = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 199) == 0) apply_reset();
        if ($urandom_range(0, 7) == 0) r = ~r;
        cycle(($urandom_range(0, 5) == 0), int'($urandom_range(0, 7)), r);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
